// File: rtl/rca_accumulator_pkg.sv
// Shared definitions for the rca_accumulator block: FSM state encoding.
// States are plain localparam constants so older tools see a fixed 2-bit code.
package rca_accumulator_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/rca_accumulator_nbit_rca.sv
// Nbit_RCA: WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
// Carry-in enters at bit 0, and the carry out of the top bit is reported as Cout.
module Nbit_RCA #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  logic [WIDTH:0] carry;

  // Each stage consumes the carry produced by the stage below it.
  always_comb begin
    carry    = '0;
    Sum      = '0;
    carry[0] = Cin;
    for (int i = 0; i < WIDTH; i++) begin
      Sum[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i+1]   = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  end

  assign Cout = carry[WIDTH];

endmodule

// File: rtl/rca_accumulator.sv
// rca_accumulator: sums a programmed number of operands through one Nbit_RCA.
// The result is reported as a wrapped sum plus the number of adder carry-outs.
module rca_accumulator
  import rca_accumulator_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] carries_q, carries_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  logic [WIDTH-1:0] rcaSum;
  logic             rcaCout;

  Nbit_RCA #(.WIDTH(WIDTH)) u_rca (
    .A    (acc_q),
    .B    (in_data),
    .Cin  (1'b0),
    .Sum  (rcaSum),
    .Cout (rcaCout)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carries_d   = carries_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d     = '0;
          carries_d = '0;
          if (len != '0) begin
            remaining_d = len;
            state_d     = ST_ACCUM;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ACCUM: begin
        // in_ready is high for the whole of ACCUM, so in_valid alone marks a transfer.
        if (in_valid) begin
          acc_d       = rcaSum;
          carries_d   = carries_q + CNT_W'(rcaCout);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      carries_q   <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carries_q   <= carries_d;
      remaining_q <= remaining_d;
    end
  end

  // The result registers double as the outputs; they only change when a new job starts.
  assign in_ready    = (state_q == ST_ACCUM);
  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign out_sum     = acc_q;
  assign out_carries = carries_q;

endmodule

// File: tb/tb_rca_accumulator.sv
// Self-checking bench for rca_accumulator: directed vector table, hand-written
// corner sequences and random jobs checked against a plain-arithmetic model.
module tb_rca_accumulator;

  localparam int WIDTH = 10;
  localparam int CNT_W = 4;
  localparam int MAXOPS = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_carries;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;

  rca_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    jobLen;
    int    ops[MAXOPS];
    int    gap;
    int    rdyDelay;
    int    expSum;
    int    expCar;
    string tag;
  } vec_t;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one job: start, operands (with optional gaps), result check, backpressure, handshake.
  task automatic applyStimulus(input int jobLen, input int ops[MAXOPS], input int gap,
                               input int rdyDelay, input bit midStart,
                               input int expSum, input int expCar, input string tag);
    start = 1'b1;
    len   = CNT_W'(jobLen);
    @(posedge clk); #1;
    start = 1'b0;
    len   = '0;
    if (jobLen == 0) checkOutput({tag, "/zeroLenInReady"}, in_ready, 0);
    for (int i = 0; i < jobLen; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_data  = WIDTH'($urandom_range(0, 1023));
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = WIDTH'(ops[i]);
      if (midStart && i == 0) begin
        start = 1'b1;
        len   = CNT_W'(5);
      end
      checkOutput({tag, "/inReady"}, in_ready, 1);
      checkOutput({tag, "/earlyValid"}, out_valid, 0);
      @(posedge clk); #1;
      start = 1'b0;
      len   = '0;
    end
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom_range(0, 1023));
    checkOutput({tag, "/outValid"}, out_valid, 1);
    checkOutput({tag, "/sum"}, out_sum, expSum);
    checkOutput({tag, "/carries"}, out_carries, expCar);
    checkOutput({tag, "/busyDone"}, busy, 1);
    for (int r = 0; r < rdyDelay; r++) begin
      @(posedge clk); #1;
      checkOutput({tag, "/heldValid"}, out_valid, 1);
      checkOutput({tag, "/heldSum"}, out_sum, expSum);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "/validDrop"}, out_valid, 0);
    checkOutput({tag, "/busyIdle"}, busy, 0);
    checkOutput({tag, "/sumKept"}, out_sum, expSum);
  endtask

  vec_t vecs[6];

  initial begin
    int ops[MAXOPS];
    int total;
    int rl;

    vecs[0] = '{jobLen:2, ops:'{0:598, 1:400, default:0}, gap:0, rdyDelay:0,
                expSum:998, expCar:0, tag:"noCarry"};
    vecs[1] = '{jobLen:3, ops:'{0:1023, 1:1023, 2:2, default:0}, gap:0, rdyDelay:0,
                expSum:0, expCar:2, tag:"carries"};
    vecs[2] = '{jobLen:0, ops:'{default:0}, gap:0, rdyDelay:0,
                expSum:0, expCar:0, tag:"zeroLen"};
    vecs[3] = '{jobLen:2, ops:'{0:222, 1:555, default:0}, gap:2, rdyDelay:3,
                expSum:777, expCar:0, tag:"backpressure"};
    vecs[4] = '{jobLen:15, ops:'{default:1023}, gap:0, rdyDelay:1,
                expSum:1009, expCar:14, tag:"maxLen"};
    vecs[5] = '{jobLen:1, ops:'{0:5, default:0}, gap:0, rdyDelay:0,
                expSum:5, expCar:0, tag:"single"};

    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset/inReady", in_ready, 0);
    checkOutput("reset/outValid", out_valid, 0);
    checkOutput("reset/busy", busy, 0);
    checkOutput("reset/sum", out_sum, 0);
    checkOutput("reset/carries", out_carries, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      applyStimulus(vecs[v].jobLen, vecs[v].ops, vecs[v].gap, vecs[v].rdyDelay, 1'b0,
                    vecs[v].expSum, vecs[v].expCar, vecs[v].tag);
    end

    // Reset in the middle of a job discards the partial result.
    start = 1'b1;
    len   = CNT_W'(3);
    @(posedge clk); #1;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b1;
    in_data  = WIDTH'(217);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midReset/inReady", in_ready, 0);
    checkOutput("midReset/outValid", out_valid, 0);
    checkOutput("midReset/busy", busy, 0);
    checkOutput("midReset/sum", out_sum, 0);
    checkOutput("midReset/carries", out_carries, 0);
    ops = '{0:217, 1:298, default:0};
    applyStimulus(2, ops, 0, 0, 1'b0, 515, 0, "afterReset");

    // A start pulse during ACCUM must not restart the job or reload len.
    ops = '{0:2, 1:98, default:0};
    applyStimulus(2, ops, 0, 0, 1'b1, 100, 0, "ignoredStart");
    ops = '{0:7, 1:9, 2:1000, default:0};
    applyStimulus(3, ops, 0, 0, 1'b0, 1016, 0, "nextStart");

    // Random jobs against an arithmetic model of the exact total.
    for (int j = 0; j < 25; j++) begin
      rl    = $urandom_range(0, MAXOPS);
      total = 0;
      ops   = '{default:0};
      for (int k = 0; k < rl; k++) begin
        ops[k] = $urandom_range(0, 1023);
        total += ops[k];
      end
      applyStimulus(rl, ops, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0,
                    total % (1 << WIDTH), total / (1 << WIDTH), $sformatf("rand%0d", j));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
